// File: rtl/uart_rx.sv
// 8N1 UART receiver with 2-FF input synchronizer and mid-bit sampling.
// Define UART_RX_PARITY_EN for 8E1 framing with a parityErrOUT strobe.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clkIN,
  input  logic       rstIN,
  input  logic       rxIN,
  output logic [7:0] dataOUT,
  output logic       validOUT,
  output logic       frameErrOUT,
  output logic       busyOUT
`ifdef UART_RX_PARITY_EN
  ,
  output logic       parityErrOUT
`endif
);

  localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] BIT_M1  = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_HIGH
  } state_t;

  state_t      state;
  logic        sync1;
  logic        rx_s;
  logic [15:0] cnt;
  logic [2:0]  idx;
  logic [7:0]  shreg;
`ifdef UART_RX_PARITY_EN
  logic        par_err;
`endif

  always_ff @(posedge clkIN) begin
    if (rstIN) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= rxIN;
      rx_s  <= sync1;
    end
  end

  always_ff @(posedge clkIN) begin
    if (rstIN) begin
      state        <= IDLE;
      cnt          <= '0;
      idx          <= '0;
      shreg        <= '0;
      dataOUT      <= '0;
      validOUT     <= 1'b0;
      frameErrOUT  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err      <= 1'b0;
      parityErrOUT <= 1'b0;
`endif
    end else begin
      validOUT     <= 1'b0;
      frameErrOUT  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parityErrOUT <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          if (cnt == HALF_M1) begin
            cnt   <= '0;
            idx   <= '0;
            state <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        DATA: begin
          if (cnt == BIT_M1) begin
            cnt   <= '0;
            shreg <= {rx_s, shreg[7:1]};
            idx   <= idx + 3'd1;
            if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt == BIT_M1) begin
            cnt     <= '0;
            par_err <= ^{shreg, rx_s};
            state   <= STOP;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
`endif
        STOP: begin
          if (cnt == BIT_M1) begin
            cnt <= '0;
            // Returning to IDLE at the stop midpoint lets an immediate next start bit through.
            if (rx_s) begin
              dataOUT      <= shreg;
              validOUT     <= 1'b1;
`ifdef UART_RX_PARITY_EN
              parityErrOUT <= par_err;
`endif
              state        <= IDLE;
            end else begin
              frameErrOUT <= 1'b1;
              state       <= WAIT_HIGH;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        WAIT_HIGH: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busyOUT = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at CLKS_PER_BIT=16; follows UART_RX_PARITY_EN when defined.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int unsigned CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME_CYC = NBITS * CPB;
  // pin drive -> sync (2 edges) -> E0, then HALF plus the remaining bit times to the stop sample
  localparam int LAT       = 3 + CPB / 2 + (NBITS - 1) * CPB;
  localparam int BUSY_CYC  = LAT - 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       ferr;
  logic       busy;
  logic       perr;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clkIN       (clk),
    .rstIN       (rst),
    .rxIN        (rx),
    .dataOUT     (data),
    .validOUT    (valid),
    .frameErrOUT (ferr),
    .busyOUT     (busy)
`ifdef UART_RX_PARITY_EN
    ,
    .parityErrOUT(perr)
`endif
  );
`ifndef UART_RX_PARITY_EN
  assign perr = 1'b0;
`endif

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int valid_count = 0;
  int ferr_count = 0;
  int busy_cycles = 0;
  int stray_perr = 0;
  int last_valid_cyc = 0;
  int prev_valid_cyc = 0;
  int last_ferr_cyc = 0;
  int frame_start = 0;

  logic [8:0] exp_q[$];
  logic [8:0] obs_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid) begin
      valid_count    <= valid_count + 1;
      prev_valid_cyc <= last_valid_cyc;
      last_valid_cyc <= cyc;
      obs_q.push_back({perr, data});
    end
    if (ferr) begin
      ferr_count    <= ferr_count + 1;
      last_ferr_cyc <= cyc;
    end
    if (busy) busy_cycles <= busy_cycles + 1;
    if (perr && !valid) stray_perr <= stray_perr + 1;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Caller must be aligned to #1 after a rising edge; returns aligned the same way.
  task automatic send_frame(input logic [7:0] b, input logic stop, input logic bad_par);
    frame_start = cyc;
    if (stop) exp_q.push_back({bad_par, b});
    rx = 1'b0;
    wait_cyc(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_cyc(CPB);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^b) ^ bad_par;
    wait_cyc(CPB);
`endif
    rx = stop;
    wait_cyc(CPB);
  endtask

  task automatic drain_sb(input string tag);
    logic [8:0] o;
    logic [8:0] e;
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL %s unexpected_byte: got data=%h perr=%b, expected no byte", tag, o[7:0], o[8]);
      end else begin
        e = exp_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL %s sb_byte: got data=%h perr=%b, expected data=%h perr=%b",
                   tag, o[7:0], o[8], e[7:0], e[8]);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx  = 1'b1;
    wait_cyc(5);
    checks++;
    if ({data, valid, ferr, busy, perr} !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs: got data=%h valid=%b ferr=%b busy=%b perr=%b, expected all 0",
               data, valid, ferr, busy, perr);
    end
    rst = 1'b0;
    wait_cyc(4);
  endtask

  task automatic test_single();
    int v0, f0, b0;
    v0 = valid_count; f0 = ferr_count; b0 = busy_cycles;
    send_frame(8'hA5, 1'b1, 1'b0);
    wait_cyc(10);
    drain_sb("single");
    checks++;
    if (valid_count !== v0 + 1) begin
      errors++;
      $display("FAIL single_valid_cycles: got %0d, expected %0d", valid_count - v0, 1);
    end
    checks++;
    if (last_valid_cyc - frame_start !== LAT) begin
      errors++;
      $display("FAIL single_latency: got %0d, expected %0d", last_valid_cyc - frame_start, LAT);
    end
    checks++;
    if (data !== 8'hA5) begin
      errors++;
      $display("FAIL single_data: got %h, expected a5", data);
    end
    checks++;
    if (ferr_count !== f0) begin
      errors++;
      $display("FAIL single_no_ferr: got %0d pulses, expected 0", ferr_count - f0);
    end
    checks++;
    if (busy_cycles - b0 !== BUSY_CYC) begin
      errors++;
      $display("FAIL single_busy_window: got %0d, expected %0d", busy_cycles - b0, BUSY_CYC);
    end
  endtask

  task automatic test_glitch();
    int v0, b0;
    v0 = valid_count; b0 = busy_cycles;
    rx = 1'b0;
    wait_cyc(3);
    rx = 1'b1;
    wait_cyc(40);
    checks++;
    if (busy_cycles - b0 !== CPB / 2) begin
      errors++;
      $display("FAIL glitch_busy: got %0d, expected %0d", busy_cycles - b0, CPB / 2);
    end
    checks++;
    if (valid_count !== v0) begin
      errors++;
      $display("FAIL glitch_no_strobe: got %0d pulses, expected 0", valid_count - v0);
    end
    checks++;
    if (data !== 8'hA5) begin
      errors++;
      $display("FAIL glitch_data: got %h, expected a5", data);
    end
  endtask

  task automatic test_frame_error();
    int v0, f0;
    v0 = valid_count; f0 = ferr_count;
    send_frame(8'h3C, 1'b0, 1'b0);
    wait_cyc(4);
    checks++;
    if (ferr_count !== f0 + 1) begin
      errors++;
      $display("FAIL ferr_pulse: got %0d, expected 1", ferr_count - f0);
    end
    checks++;
    if (last_ferr_cyc - frame_start !== LAT) begin
      errors++;
      $display("FAIL ferr_latency: got %0d, expected %0d", last_ferr_cyc - frame_start, LAT);
    end
    checks++;
    if (data !== 8'hA5) begin
      errors++;
      $display("FAIL ferr_data_held: got %h, expected a5", data);
    end
    wait_cyc(40 * CPB);
    checks++;
    if (ferr_count !== f0 + 1 || valid_count !== v0) begin
      errors++;
      $display("FAIL break_pulses: got ferr=%0d valid=%0d, expected ferr=1 valid=0",
               ferr_count - f0, valid_count - v0);
    end
    rx = 1'b1;
    wait_cyc(2 * CPB);
    send_frame(8'h12, 1'b1, 1'b0);
    wait_cyc(10);
    drain_sb("after_break");
    checks++;
    if (data !== 8'h12) begin
      errors++;
      $display("FAIL after_break_data: got %h, expected 12", data);
    end
  endtask

  task automatic test_back_to_back();
    int v0;
    v0 = valid_count;
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    wait_cyc(10);
    drain_sb("b2b");
    checks++;
    if (valid_count !== v0 + 2) begin
      errors++;
      $display("FAIL b2b_count: got %0d, expected 2", valid_count - v0);
    end
    checks++;
    if (last_valid_cyc - prev_valid_cyc !== FRAME_CYC) begin
      errors++;
      $display("FAIL b2b_spacing: got %0d, expected %0d", last_valid_cyc - prev_valid_cyc, FRAME_CYC);
    end
    checks++;
    if (data !== 8'hFF) begin
      errors++;
      $display("FAIL b2b_data: got %h, expected ff", data);
    end
  endtask

  task automatic test_reset_mid();
    int v0, f0;
    logic [7:0] b;
    b = 8'h5A;
    v0 = valid_count; f0 = ferr_count;
    rx = 1'b0;
    wait_cyc(CPB);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      wait_cyc(CPB);
    end
    rx = b[4];
    wait_cyc(CPB / 2);
    rst = 1'b1;
    wait_cyc(1);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_busy: got %b, expected 0", busy);
    end
    checks++;
    if (data !== 8'h00) begin
      errors++;
      $display("FAIL midreset_data: got %h, expected 00", data);
    end
    rst = 1'b0;
    rx  = 1'b1;
    wait_cyc(FRAME_CYC + 20);
    checks++;
    if (valid_count !== v0 || ferr_count !== f0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_quiet: got valid=%0d ferr=%0d busy=%b, expected 0 0 0",
               valid_count - v0, ferr_count - f0, busy);
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    send_frame(8'h07, 1'b1, 1'b1);
    wait_cyc(10);
    drain_sb("parity_bad");
    checks++;
    if (data !== 8'h07) begin
      errors++;
      $display("FAIL parity_data: got %h, expected 07", data);
    end
    send_frame(8'h81, 1'b1, 1'b0);
    wait_cyc(10);
    drain_sb("parity_good");
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_glitch();
    test_frame_error();
    test_back_to_back();
    test_reset_mid();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    wait_cyc(5);
    drain_sb("final");
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL missing_bytes: got %0d pending, expected 0", exp_q.size());
    end
    checks++;
    if (stray_perr !== 0) begin
      errors++;
      $display("FAIL stray_parity: got %0d, expected 0", stray_perr);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver for the UART echo design: it recovers 8N1 frames from the raw `rxIN` pin and presents each received byte on a parallel bus. It sits directly upstream of the two-digit hex seven-segment display driver, whose 8-bit data input takes `dataOUT` directly. A one-cycle strobe also marks each new byte for the echo transmitter.

## Interface
- `CLKS_PER_BIT`, default 434: clkIN cycles per bit time (50 MHz / 115200); legal range 4..65535.
- `clkIN  input  1` — system clock; all logic is on the rising edge.
- `rstIN  input  1` — reset, synchronous and active-high.
- `rxIN  input  1` — serial line, asynchronous, idle high.
- `dataOUT  output  8` — last correctly framed byte, held until the next good frame.
- `validOUT  output  1` — one-cycle pulse when `dataOUT` has just been updated.
- `frameErrOUT  output  1` — one-cycle pulse when a stop bit is sampled low.
- `busyOUT  output  1` — high in every state except IDLE.
- `parityErrOUT  output  1` — present only with `UART_RX_PARITY_EN`; see Configuration.

## Operation
- **Synchronizer:** `rxIN` passes through a 2-FF synchronizer to give `rx_s`. Both flops reset to 1.
- **Constants:** HALF = CLKS_PER_BIT/2 (integer division). The bit counter is 16 bits wide and the bit index is 3 bits wide.
- **FSM states:** IDLE, START, DATA, STOP, WAIT_HIGH (PARITY is added with the macro).
  - IDLE: if `rx_s`=0, go to START with cnt=0.
  - START: cnt increments each cycle. When cnt=HALF-1, sample `rx_s`:
    - 0: go to DATA with cnt=0 and idx=0.
    - 1: false start; go to IDLE with no output.
  - DATA: when cnt=CLKS_PER_BIT-1, shift `rx_s` into the shift register LSB-first, reset cnt to 0 and increment idx. After idx=7 is sampled, go to STOP.
  - STOP: when cnt=CLKS_PER_BIT-1, sample `rx_s`:
    - 1: load `dataOUT` from the shift register, pulse `validOUT`, go to IDLE.
    - 0: pulse `frameErrOUT`, leave `dataOUT` unchanged, go to WAIT_HIGH.
  - WAIT_HIGH: stay until `rx_s`=1, then go to IDLE. A held-low line (break) therefore reports exactly one frame error.
- **Back-to-back frames:** IDLE is entered at the stop-bit midpoint, so a start bit that immediately follows the stop bit is accepted.
- **Reset values:** `dataOUT`=0, `validOUT`=0, `frameErrOUT`=0, `busyOUT`=0, `parityErrOUT`=0, state=IDLE, counters=0, synchronizer=1.
- **Reset mid-frame:** the partial byte is discarded, no strobe is generated, and `busyOUT`=0 in the cycle after reset is sampled.
- **Output registering:** all outputs are registered; `busyOUT` is decoded from the registered state.

## Timing
- **Reference edge E0:** the first clkIN edge at which the FSM sees `rx_s`=0 in IDLE. This is 2 edges after the edge that first samples the pin low.
- **Sample points:**
  - start-bit check at E0+HALF;
  - data bit k (k=0..7) at E0+HALF+(k+1)·CLKS_PER_BIT;
  - stop bit at E0+HALF+9·CLKS_PER_BIT.
- **Strobe timing:**
  - `validOUT` or `frameErrOUT` is high for exactly the one cycle following the stop-sample edge.
  - `dataOUT` changes on that same edge.
- **Busy window:** `busyOUT` rises the cycle after E0 and falls the cycle after the stop sample, or after the WAIT_HIGH exit.
- **Throughput:** one byte per 10 bit times; there is no buffering and no backpressure. The consumer must take `dataOUT` within one frame time.

## Configuration
- **`UART_RX_PARITY_EN` defined:**
  - Frames are 8E1; a PARITY state is inserted between DATA and STOP.
  - The parity bit is sampled at E0+HALF+9·CLKS_PER_BIT and the stop bit at E0+HALF+10·CLKS_PER_BIT.
  - `parityErrOUT` pulses in the same cycle as `validOUT` when the XOR of the 8 data bits and the parity bit is 1.
  - The byte is still delivered on a parity error.
  - A bad stop bit takes precedence: `frameErrOUT` pulses and `parityErrOUT` stays 0.
- **`UART_RX_PARITY_EN` undefined:** 8N1 framing, and the `parityErrOUT` port does not exist.

## Test plan
All scenarios use CLKS_PER_BIT=16 (HALF=8).
- **Reset:** hold `rstIN`=1 for 5 cycles with `rxIN`=1 → all outputs 0 and `busyOUT`=0.
- **Single frame:** send 0xA5 in 8N1 → `validOUT` is high for 1 cycle exactly at E0+152+1, `dataOUT`=8'hA5, `frameErrOUT` never asserts.
- **Glitch:** drive `rxIN` low for 3 cycles, then high → no strobe, `busyOUT` high for 8 cycles only, `dataOUT` keeps 8'hA5.
- **Frame error and break:**
  - send 0x3C with the stop bit low → one `frameErrOUT` pulse and `dataOUT` still 8'hA5;
  - then hold the line low for 40 bit times → no further pulses;
  - on release, send 0x12 → `dataOUT`=8'h12.
- **Back-to-back:** send 0x00 then 0xFF with no idle gap → two `validOUT` pulses 160 cycles apart, with `dataOUT` 8'h00 then 8'hFF.
- **Reset mid-frame, and parity (parity only with `UART_RX_PARITY_EN`):**
  - assert `rstIN` during data bit 4 → `busyOUT`=0 next cycle, and no strobe for that frame;
  - with the macro defined, send 0x07 with parity bit 0 → `validOUT` and `parityErrOUT` pulse together, and `dataOUT`=8'h07.
